// File: rtl/axi4_lite_master_pkg.sv
// Shared AXI4-Lite definitions.
// Holds the address/data widths used by the master, its companion slave and
// the bench, plus the state encodings of the master's write and read FSMs.
// No ports: this file is a package only.
package axi4_lite_Defs;

   localparam int Addr_Width = 32;
   localparam int Data_Width = 32;

   // Write side: idle, address+data channels in flight, waiting for response
   typedef enum logic [1:0] {
      W_IDLE      = 2'd0,
      W_ADDR_DATA = 2'd1,
      W_RESP      = 2'd2
   } writeState_t;

   // Read side: idle, address channel in flight, waiting for read data
   typedef enum logic [1:0] {
      R_IDLE = 2'd0,
      R_ADDR = 2'd1,
      R_DATA = 2'd2
   } readState_t;

endpackage

// File: rtl/axi4_lite_master.sv
// AXI4-Lite master with independent read and write engines.
// A single-beat write is launched by sampling wr_en while the write side is
// idle; a single-beat read by sampling rd_en while the read side is idle.
// Both sides may run at the same time. Requests arriving while a side is
// busy are dropped, not queued.
//
// Ports
//   ACLK, ARESETN                  clock, asynchronous active-low reset
//   rd_en, Read_Address            read request and its address
//   wr_en, Write_Address,
//   Write_Data                     write request, its address and data
//   Read_Data                      data of the last completed read
//   AW*/W*/B*                      AXI4-Lite write address/data/response
//   AR*/R*                         AXI4-Lite read address/data
module axi4_lite_master
   import axi4_lite_Defs::*;
(
   input  logic                  ACLK,
   input  logic                  ARESETN,

   input  logic                  rd_en,
   input  logic                  wr_en,
   input  logic [Addr_Width-1:0] Read_Address,
   input  logic [Addr_Width-1:0] Write_Address,
   input  logic [Data_Width-1:0] Write_Data,
   output logic [Data_Width-1:0] Read_Data,

   output logic [Addr_Width-1:0] AWADDR,
   output logic                  AWVALID,
   input  logic                  AWREADY,
   output logic [Data_Width-1:0] WDATA,
   output logic                  WVALID,
   input  logic                  WREADY,
   input  logic [1:0]            BRESP,
   input  logic                  BVALID,
   output logic                  BREADY,

   output logic [Addr_Width-1:0] ARADDR,
   output logic                  ARVALID,
   input  logic                  ARREADY,
   input  logic [Data_Width-1:0] RDATA,
   input  logic [1:0]            RRESP,
   input  logic                  RVALID,
   output logic                  RREADY
);

   writeState_t writeState;
   readState_t  readState;

   logic awFinishing;
   logic wFinishing;
   logic unusedResp;

   // A write channel counts as finished once its VALID has already dropped
   // or its handshake is happening on this edge. Requiring both lets the AW
   // and W handshakes land in either order or on the same edge.
   assign awFinishing = !AWVALID || AWREADY;
   assign wFinishing  = !WVALID  || WREADY;

   // Response codes only mark completion; this master does not act on them.
   assign unusedResp = ^{BRESP, RRESP};

   // Write engine. All outputs are registers, so no VALID ever follows a
   // READY combinationally. AWADDR/WDATA are loaded only from idle, which
   // keeps them stable for as long as their VALID is high.
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         writeState <= W_IDLE;
         AWADDR     <= '0;
         WDATA      <= '0;
         AWVALID    <= 1'b0;
         WVALID     <= 1'b0;
         BREADY     <= 1'b0;
      end else begin
         case (writeState)
            W_IDLE: begin
               if (wr_en) begin
                  AWADDR     <= Write_Address;
                  WDATA      <= Write_Data;
                  AWVALID    <= 1'b1;
                  WVALID     <= 1'b1;
                  writeState <= W_ADDR_DATA;
               end
            end
            W_ADDR_DATA: begin
               if (AWVALID && AWREADY) begin
                  AWVALID <= 1'b0;
               end
               if (WVALID && WREADY) begin
                  WVALID <= 1'b0;
               end
               if (awFinishing && wFinishing) begin
                  BREADY     <= 1'b1;
                  writeState <= W_RESP;
               end
            end
            W_RESP: begin
               if (BVALID) begin
                  BREADY     <= 1'b0;
                  writeState <= W_IDLE;
               end
            end
            default: begin
               AWVALID    <= 1'b0;
               WVALID     <= 1'b0;
               BREADY     <= 1'b0;
               writeState <= W_IDLE;
            end
         endcase
      end
   end

   // Read engine. ARADDR is loaded only from idle; Read_Data is updated only
   // by a completed R handshake and otherwise holds the last read result.
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         readState <= R_IDLE;
         ARADDR    <= '0;
         ARVALID   <= 1'b0;
         RREADY    <= 1'b0;
         Read_Data <= '0;
      end else begin
         case (readState)
            R_IDLE: begin
               if (rd_en) begin
                  ARADDR    <= Read_Address;
                  ARVALID   <= 1'b1;
                  readState <= R_ADDR;
               end
            end
            R_ADDR: begin
               if (ARREADY) begin
                  ARVALID   <= 1'b0;
                  RREADY    <= 1'b1;
                  readState <= R_DATA;
               end
            end
            R_DATA: begin
               if (RVALID) begin
                  Read_Data <= RDATA;
                  RREADY    <= 1'b0;
                  readState <= R_IDLE;
               end
            end
            default: begin
               ARVALID   <= 1'b0;
               RREADY    <= 1'b0;
               readState <= R_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_axi4_lite_master.sv
// Bench for axi4_lite_master. The bench plays the AXI slave (a word memory
// with programmable READY/VALID delays) and keeps its own reference memory
// for the values reads must return.
module tb_axi4_lite_master;
   import axi4_lite_Defs::*;

   logic                  ACLK;
   logic                  ARESETN;
   logic                  rd_en;
   logic                  wr_en;
   logic [Addr_Width-1:0] Read_Address;
   logic [Addr_Width-1:0] Write_Address;
   logic [Data_Width-1:0] Write_Data;
   logic [Data_Width-1:0] Read_Data;
   logic [Addr_Width-1:0] AWADDR;
   logic                  AWVALID;
   logic                  AWREADY;
   logic [Data_Width-1:0] WDATA;
   logic                  WVALID;
   logic                  WREADY;
   logic [1:0]            BRESP;
   logic                  BVALID;
   logic                  BREADY;
   logic [Addr_Width-1:0] ARADDR;
   logic                  ARVALID;
   logic                  ARREADY;
   logic [Data_Width-1:0] RDATA;
   logic [1:0]            RRESP;
   logic                  RVALID;
   logic                  RREADY;

   axi4_lite_master dut (
      .ACLK(ACLK), .ARESETN(ARESETN),
      .rd_en(rd_en), .wr_en(wr_en),
      .Read_Address(Read_Address), .Write_Address(Write_Address),
      .Write_Data(Write_Data), .Read_Data(Read_Data),
      .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
      .WDATA(WDATA), .WVALID(WVALID), .WREADY(WREADY),
      .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
      .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
      .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY)
   );

   typedef struct {
      bit          doWrite;
      bit          doRead;
      logic [31:0] wAddr;
      logic [31:0] wData;
      logic [31:0] rAddr;
      int          awD, wD, bD, arD, rD;
      logic [31:0] expRead;
      int          expWLat;
      int          expRLat;
   } vec_t;

   int checks = 0;
   int errors = 0;

   int awDelay = 0, wDelay = 0, bDelay = 0, arDelay = 0, rDelay = 0;
   int awCount = 0, bCount = 0, rCount = 0, awHigh = 0, wHigh = 0;

   logic [31:0] mem [256];
   logic [31:0] modelMem [256];

   // Free-running clock, period 10
   initial begin
      ACLK = 1'b0;
      forever #5 ACLK = ~ACLK;
   end

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
      end
   endtask

   // Slave model. At each falling edge it first books the handshakes that
   // the previous rising edge completed, checks the master's VALID/READY
   // behaviour around them, then presents new READY/VALID values.
   initial begin : slaveModel
      bit awPend, wPend, bPend, arPend, rPend;
      bit awGot, wGot, arGot;
      bit prevAw, prevW, prevAr;
      logic [31:0] prevAwAddr, prevWData, prevArAddr;
      logic [31:0] pendAwAddr, pendWData, pendArAddr;
      logic [31:0] slvAwAddr, slvWData, slvArAddr;
      int awWait, wWait, bWait, arWait, rWait;
      AWREADY = 0; WREADY = 0; BVALID = 0; BRESP = 0;
      ARREADY = 0; RVALID = 0; RDATA = 0; RRESP = 0;
      for (int i = 0; i < 256; i++) mem[i] = 32'hA500_0000 | i;
      forever begin
         @(negedge ACLK);
         if (!ARESETN) begin
            AWREADY = 0; WREADY = 0; BVALID = 0; ARREADY = 0; RVALID = 0;
            awPend = 0; wPend = 0; bPend = 0; arPend = 0; rPend = 0;
            awGot = 0; wGot = 0; arGot = 0;
            prevAw = 0; prevW = 0; prevAr = 0;
            awWait = 0; wWait = 0; bWait = 0; arWait = 0; rWait = 0;
         end else begin
            if (awPend) begin
               awGot = 1; awWait = 0; awCount++; slvAwAddr = pendAwAddr;
               checkOutput("awvalid_drop", {31'd0, AWVALID}, 0);
            end else if (prevAw) begin
               checkOutput("awvalid_hold", {31'd0, AWVALID}, 1);
               checkOutput("awaddr_stable", AWADDR, prevAwAddr);
            end
            if (wPend) begin
               wGot = 1; wWait = 0; slvWData = pendWData;
               checkOutput("wvalid_drop", {31'd0, WVALID}, 0);
            end else if (prevW) begin
               checkOutput("wvalid_hold", {31'd0, WVALID}, 1);
               checkOutput("wdata_stable", WDATA, prevWData);
            end
            if (bPend) begin
               mem[slvAwAddr[9:2]] = slvWData;
               awGot = 0; wGot = 0; bWait = 0; bCount++;
               checkOutput("bready_drop", {31'd0, BREADY}, 0);
            end
            if (arPend) begin
               arGot = 1; arWait = 0; slvArAddr = pendArAddr;
               checkOutput("arvalid_drop", {31'd0, ARVALID}, 0);
            end else if (prevAr) begin
               checkOutput("arvalid_hold", {31'd0, ARVALID}, 1);
               checkOutput("araddr_stable", ARADDR, prevArAddr);
            end
            if (rPend) begin
               arGot = 0; rWait = 0; rCount++;
               checkOutput("rready_drop", {31'd0, RREADY}, 0);
            end

            if (AWVALID) awHigh++;
            if (WVALID) wHigh++;
            prevAw = AWVALID; prevAwAddr = AWADDR;
            prevW  = WVALID;  prevWData  = WDATA;
            prevAr = ARVALID; prevArAddr = ARADDR;

            AWREADY = 0;
            if (AWVALID && !awGot) begin
               if (awWait >= awDelay) AWREADY = 1; else awWait++;
            end
            WREADY = 0;
            if (WVALID && !wGot) begin
               if (wWait >= wDelay) WREADY = 1; else wWait++;
            end
            BVALID = 0;
            if (awGot && wGot) begin
               if (bWait >= bDelay) BVALID = 1; else bWait++;
            end
            ARREADY = 0;
            if (ARVALID && !arGot) begin
               if (arWait >= arDelay) ARREADY = 1; else arWait++;
            end
            RVALID = 0;
            if (arGot) begin
               if (rWait >= rDelay) begin
                  RVALID = 1; RDATA = mem[slvArAddr[9:2]];
               end else rWait++;
            end

            awPend = AWVALID && AWREADY; pendAwAddr = AWADDR;
            wPend  = WVALID && WREADY;   pendWData  = WDATA;
            bPend  = BVALID && BREADY;
            arPend = ARVALID && ARREADY; pendArAddr = ARADDR;
            rPend  = RVALID && RREADY;
         end
      end
   end

   // Issues one write and/or read request for a single cycle, then waits
   // (bounded) for completion. Latencies are counted in falling edges from
   // the cycle the request was raised to the cycle the slave booked it.
   task automatic applyStimulus(input bit doWrite, input bit doRead,
                                input logic [31:0] wAddr, input logic [31:0] wData,
                                input logic [31:0] rAddr,
                                output int wLat, output int rLat);
      int b0, r0;
      bit wDone, rDone;
      b0 = bCount; r0 = rCount; wLat = -1; rLat = -1;
      wDone = !doWrite; rDone = !doRead;
      @(negedge ACLK); #1;
      wr_en = doWrite; rd_en = doRead;
      Write_Address = wAddr; Write_Data = wData; Read_Address = rAddr;
      for (int n = 1; n <= 80 && !(wDone && rDone); n++) begin
         @(negedge ACLK); #1;
         if (n == 1) begin wr_en = 0; rd_en = 0; end
         if (!wDone && bCount != b0) begin wDone = 1; wLat = n; end
         if (!rDone && rCount != r0) begin rDone = 1; rLat = n; end
      end
      if (!(wDone && rDone)) begin
         checks++; errors++;
         $display("[TB] FAIL transaction_timeout: write done=%0d read done=%0d, required 1 and 1",
                  wDone, rDone);
      end
   endtask

   initial begin : mainTest
      vec_t vecs[18];
      int wLat, rLat, aw0, b0, wIdx, rIdx;
      bit found;

      // Table of randomized transactions in a region the directed tests
      // never touch; expectations come from a plain reference memory.
      for (int i = 0; i < 256; i++) modelMem[i] = 32'hA500_0000 | i;
      for (int i = 0; i < 18; i++) begin
         vecs[i].doWrite = (i % 3) != 1;
         vecs[i].doRead  = (i % 3) != 0;
         wIdx = 128 + $urandom_range(0, 127);
         rIdx = 128 + $urandom_range(0, 127);
         if (vecs[i].doWrite && vecs[i].doRead && rIdx == wIdx) rIdx = 128 + ((rIdx - 127) % 128);
         vecs[i].wAddr = 32'(wIdx) << 2;
         vecs[i].rAddr = 32'(rIdx) << 2;
         vecs[i].wData = $urandom;
         if (i < 3) begin
            vecs[i].awD = 0; vecs[i].wD = 0; vecs[i].bD = 0; vecs[i].arD = 0; vecs[i].rD = 0;
         end else begin
            vecs[i].awD = $urandom_range(0, 3); vecs[i].wD = $urandom_range(0, 3);
            vecs[i].bD  = $urandom_range(0, 3); vecs[i].arD = $urandom_range(0, 3);
            vecs[i].rD  = $urandom_range(0, 3);
         end
         vecs[i].expRead = modelMem[rIdx];
         if (vecs[i].doWrite) modelMem[wIdx] = vecs[i].wData;
         vecs[i].expWLat = 3 + ((vecs[i].awD > vecs[i].wD) ? vecs[i].awD : vecs[i].wD) + vecs[i].bD;
         vecs[i].expRLat = 3 + vecs[i].arD + vecs[i].rD;
      end

      ARESETN = 0; rd_en = 0; wr_en = 0;
      Read_Address = 0; Write_Address = 0; Write_Data = 0;
      #12;
      checkOutput("reset_valid_ready", {27'd0, AWVALID, WVALID, BREADY, ARVALID, RREADY}, 0);
      checkOutput("reset_awaddr", AWADDR, 0);
      checkOutput("reset_wdata", WDATA, 0);
      checkOutput("reset_araddr", ARADDR, 0);
      checkOutput("reset_read_data", Read_Data, 0);
      @(negedge ACLK); #1;
      ARESETN = 1;
      for (int k = 0; k < 3; k++) begin
         @(negedge ACLK); #1;
         checkOutput("idle_after_reset", {27'd0, AWVALID, WVALID, BREADY, ARVALID, RREADY}, 0);
      end

      // Zero-wait write then read back
      $display("[TB] zero-wait write/read");
      awHigh = 0; wHigh = 0; aw0 = awCount;
      applyStimulus(1, 0, 32'h10, 32'hDEADBEEF, 0, wLat, rLat);
      checkOutput("zw_write_latency", wLat, 3);
      checkOutput("zw_awvalid_cycles", awHigh, 1);
      checkOutput("zw_wvalid_cycles", wHigh, 1);
      checkOutput("zw_aw_handshakes", awCount - aw0, 1);
      checkOutput("zw_awaddr", AWADDR, 32'h10);
      checkOutput("zw_wdata", WDATA, 32'hDEADBEEF);
      modelMem[4] = 32'hDEADBEEF;
      applyStimulus(0, 1, 0, 0, 32'h10, wLat, rLat);
      checkOutput("zw_read_latency", rLat, 3);
      checkOutput("zw_read_data", Read_Data, 32'hDEADBEEF);

      // AWREADY late by 3 cycles, WREADY immediate
      $display("[TB] delayed AWREADY");
      awDelay = 3; awHigh = 0; wHigh = 0; aw0 = awCount; b0 = bCount;
      applyStimulus(1, 0, 32'h20, 32'h0BADF00D, 0, wLat, rLat);
      checkOutput("slow_aw_awvalid_cycles", awHigh, 4);
      checkOutput("slow_aw_wvalid_cycles", wHigh, 1);
      checkOutput("slow_aw_b_handshakes", bCount - b0, 1);
      checkOutput("slow_aw_write_latency", wLat, 6);
      modelMem[8] = 32'h0BADF00D;
      awDelay = 0;

      // Simultaneous read and write to different addresses
      $display("[TB] concurrent read and write");
      applyStimulus(1, 1, 32'h30, 32'hCAFE1234, 32'h20, wLat, rLat);
      checkOutput("conc_write_latency", wLat, 3);
      checkOutput("conc_read_latency", rLat, 3);
      checkOutput("conc_read_data", Read_Data, modelMem[8]);
      modelMem[12] = 32'hCAFE1234;
      applyStimulus(0, 1, 0, 0, 32'h30, wLat, rLat);
      checkOutput("conc_readback", Read_Data, modelMem[12]);

      // Second wr_en while waiting for the write response must be dropped
      $display("[TB] wr_en during response phase");
      bDelay = 3; aw0 = awCount; b0 = bCount;
      @(negedge ACLK); #1;
      wr_en = 1; Write_Address = 32'h40; Write_Data = 32'h12345678;
      @(negedge ACLK); #1;
      wr_en = 0;
      found = 0;
      for (int n = 0; n < 20 && !found; n++) begin
         if (BREADY) found = 1;
         else begin @(negedge ACLK); #1; end
      end
      checkOutput("resp_phase_reached", {31'd0, found}, 1);
      wr_en = 1; Write_Address = 32'h44; Write_Data = 32'hBAD0BAD0;
      @(negedge ACLK); #1;
      wr_en = 0;
      for (int n = 0; n < 20 && bCount == b0; n++) begin @(negedge ACLK); #1; end
      for (int n = 0; n < 5; n++) begin @(negedge ACLK); #1; end
      checkOutput("busy_aw_handshakes", awCount - aw0, 1);
      checkOutput("busy_b_handshakes", bCount - b0, 1);
      checkOutput("busy_awvalid_idle", {31'd0, AWVALID}, 0);
      checkOutput("busy_awaddr_kept", AWADDR, 32'h40);
      modelMem[16] = 32'h12345678;
      bDelay = 0;
      applyStimulus(0, 1, 0, 0, 32'h40, wLat, rLat);
      checkOutput("busy_readback", Read_Data, modelMem[16]);
      applyStimulus(0, 1, 0, 0, 32'h44, wLat, rLat);
      checkOutput("busy_untouched", Read_Data, modelMem[17]);

      // Reset in the middle of a read address phase
      $display("[TB] reset during read");
      arDelay = 10;
      @(negedge ACLK); #1;
      rd_en = 1; Read_Address = 32'h20;
      @(negedge ACLK); #1;
      rd_en = 0;
      @(negedge ACLK); #1;
      checkOutput("pre_reset_arvalid", {31'd0, ARVALID}, 1);
      ARESETN = 0;
      #1;
      checkOutput("async_reset_arvalid", {31'd0, ARVALID}, 0);
      checkOutput("async_reset_rready", {31'd0, RREADY}, 0);
      checkOutput("async_reset_read_data", Read_Data, 0);
      checkOutput("async_reset_araddr", ARADDR, 0);
      checkOutput("async_reset_awaddr", AWADDR, 0);
      @(negedge ACLK); #1;
      @(negedge ACLK); #1;
      ARESETN = 1; arDelay = 0;
      for (int k = 0; k < 3; k++) begin
         @(negedge ACLK); #1;
         checkOutput("quiet_after_reset", {27'd0, AWVALID, WVALID, BREADY, ARVALID, RREADY}, 0);
         checkOutput("quiet_read_data", Read_Data, 0);
      end
      applyStimulus(0, 1, 0, 0, 32'h30, wLat, rLat);
      checkOutput("post_reset_read_latency", rLat, 3);
      checkOutput("post_reset_read_data", Read_Data, modelMem[12]);

      // Randomized table
      $display("[TB] randomized table");
      for (int i = 0; i < 18; i++) begin
         awDelay = vecs[i].awD; wDelay = vecs[i].wD; bDelay = vecs[i].bD;
         arDelay = vecs[i].arD; rDelay = vecs[i].rD;
         applyStimulus(vecs[i].doWrite, vecs[i].doRead, vecs[i].wAddr, vecs[i].wData,
                       vecs[i].rAddr, wLat, rLat);
         if (vecs[i].doWrite) checkOutput($sformatf("vec%0d_write_latency", i), wLat, vecs[i].expWLat);
         if (vecs[i].doRead) begin
            checkOutput($sformatf("vec%0d_read_latency", i), rLat, vecs[i].expRLat);
            checkOutput($sformatf("vec%0d_read_data", i), Read_Data, vecs[i].expRead);
         end
      end
      awDelay = 0; wDelay = 0; bDelay = 0; arDelay = 0; rDelay = 0;
      for (int i = 0; i < 18; i++) begin
         if (vecs[i].doWrite) begin
            applyStimulus(0, 1, 0, 0, vecs[i].wAddr, wLat, rLat);
            checkOutput($sformatf("vec%0d_readback", i), Read_Data, modelMem[vecs[i].wAddr[9:2]]);
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
